gate_bist_ctrl: RTL

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

---
 rtl/gate_bist_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/gate_bist_ctrl.sv
// Exhaustive built-in self test sequencer for a small combinational gate.
// Walks every input vector in ascending order and lets each one settle for a
// fixed number of cycles. It then compares the gate output with the matching
// bit of the golden truth table. Mismatches are counted, and the lowest
// failing vector is remembered.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; outputs hold results of last run
// SETTLE | vector applied, wait counter running for SETTLE cycles
// SAMPLE | one cycle: compare gate_out with golden[vector]
// DONE   | one cycle: done pulse, pass result latched
module gate_bist_ctrl #(
  parameter int N      = 2,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [2**N-1:0] golden,
  input  logic            gate_out,
  output logic [N-1:0]    stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N:0]      fail_count,
  output logic [N-1:0]    first_fail
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0]   WAIT_LAST = 4'(SETTLE - 1);
  localparam logic [N-1:0] VEC_LAST  = '1;
  // Saturation bound; can never actually be exceeded because each vector
  // is sampled at most once per run.
  localparam logic [N:0]   FAIL_MAX  = (N+1)'(2**N);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] stim_q, stim_d;
  logic [N-1:0] vec_q, vec_d;
  logic [3:0]   wait_q, wait_d;
  logic         pass_q, pass_d;
  logic [N:0]   fail_q, fail_d;
  logic [N-1:0] first_q, first_d;

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_SETTLE;
          stim_d  = '0;
          vec_d   = '0;
          wait_d  = '0;
          fail_d  = '0;
          first_d = '0;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        // An abort here discards the comparison of the current vector.
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else begin
          if (gate_out != golden[vec_q]) begin
            if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
            if (fail_q == '0) first_d = vec_q;
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETTLE;
            vec_d   = vec_q + 1'b1;
            stim_d  = vec_q + 1'b1;
            wait_d  = '0;
          end
        end
      end
      default: begin
        // fail_q already includes the final sample, registered on entry here.
        pass_d  = (fail_q == '0);
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      vec_q   <= '0;
      wait_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      first_q <= first_d;
    end
  end

  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done       = (state_q == ST_DONE);
  assign stim       = stim_q;
  assign pass       = pass_q;
  assign fail_count = fail_q;
  assign first_fail = first_q;

endmodule
